// File: rtl/layer6_result_buffer.sv
// layer6_result_buffer: frame store between layer-6 pooling and layer-7 conv; writes fill a frame, reads serve it until release.
// Define LAYER6_BUF_ZERO_PAD_EN to answer out-of-range reads with valid zero data (padding ring).
module layer6_result_buffer #(
   parameter int DATA_W = 128,
   parameter int ROWS   = 8,
   parameter int COLS   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              save_enable_i,
   input  logic [15:0]       save_row_i,
   input  logic [15:0]       save_col_i,
   input  logic [DATA_W-1:0] save_data_i,
   input  logic              read_pixel_signal_i,
   input  logic [15:0]       read_row_addr_i,
   input  logic [15:0]       read_col_addr_i,
   input  logic              layer7_release_i,
   output logic              pixel_store_done_o,
   output logic [DATA_W-1:0] read_data_o,
   output logic              read_valid_o,
   output logic              overflow_o
);
   localparam int N  = ROWS * COLS;
   localparam int CW = $clog2(N + 1);
   localparam int AW = $clog2(N);
   typedef enum logic {FILL, READY} state_t;
   state_t            state_q, state_d;
   logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
   logic              ovf_q, ovf_d, rv_q, rv_d;
   logic [DATA_W-1:0] rd_q, rd_d;
   logic [DATA_W-1:0] mem [N];
   logic              wr_ok, rd_ok, rd_in;
   logic [AW-1:0]     wr_idx, rd_idx;
   assign wr_ok = save_enable_i && save_row_i < 16'(ROWS) && save_col_i < 16'(COLS)
                  && (state_q == FILL || layer7_release_i);
   assign rd_in = !read_row_addr_i[15] && !read_col_addr_i[15]
                  && read_row_addr_i < 16'(ROWS) && read_col_addr_i < 16'(COLS);
   assign rd_ok  = read_pixel_signal_i && state_q == READY;
   assign wr_idx = AW'(int'(save_row_i) * COLS + int'(save_col_i));
   assign rd_idx = AW'(int'(read_row_addr_i) * COLS + int'(read_col_addr_i));
   always_comb begin
      state_d  = state_q;
      wr_cnt_d = wr_cnt_q;
      ovf_d    = ovf_q | (save_enable_i && !wr_ok);
      // a release in READY opens the next frame before the same-cycle write is counted
      if (state_q == READY && layer7_release_i) begin
         state_d  = FILL;
         wr_cnt_d = '0;
      end
      if (wr_ok) begin
         wr_cnt_d = wr_cnt_d + CW'(1);
         if (wr_cnt_d == CW'(N)) state_d = READY;
      end
`ifdef LAYER6_BUF_ZERO_PAD_EN
      rv_d = rd_ok;
`else
      rv_d = rd_ok && rd_in;
`endif
      rd_d = (rd_ok && rd_in) ? mem[rd_idx] : '0;
   end
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_idx] <= save_data_i;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= FILL;
         wr_cnt_q <= '0;
         ovf_q    <= 1'b0;
         rv_q     <= 1'b0;
         rd_q     <= '0;
      end else begin
         state_q  <= state_d;
         wr_cnt_q <= wr_cnt_d;
         ovf_q    <= ovf_d;
         rv_q     <= rv_d;
         rd_q     <= rd_d;
      end
   end
   assign pixel_store_done_o = state_q == READY;
   assign read_data_o        = rd_q;
   assign read_valid_o       = rv_q;
   assign overflow_o         = ovf_q;
endmodule

// File: tb/tb_layer6_result_buffer.sv
// tb_layer6_result_buffer: directed and randomized frame fill/read/release checks against a frame-level model.
module tb_layer6_result_buffer;
`ifdef LAYER6_BUF_ZERO_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif
   logic clk = 1'b0, rst_n = 1'b1;
   logic save_enable_i = 1'b0, read_pixel_signal_i = 1'b0, layer7_release_i = 1'b0;
   logic [15:0] save_row_i = '0, save_col_i = '0, read_row_addr_i = '0, read_col_addr_i = '0;
   logic [127:0] save_data_i = '0;
   logic pixel_store_done_o, read_valid_o, overflow_o;
   logic [127:0] read_data_o;
   logic [127:0] m [64];
   int cnt = 0, n_chk = 0, n_fail = 0;
   bit rdy = 1'b0, ovf = 1'b0;
   layer6_result_buffer dut (
      .clk(clk), .rst_n(rst_n), .save_enable_i(save_enable_i), .save_row_i(save_row_i),
      .save_col_i(save_col_i), .save_data_i(save_data_i), .read_pixel_signal_i(read_pixel_signal_i),
      .read_row_addr_i(read_row_addr_i), .read_col_addr_i(read_col_addr_i),
      .layer7_release_i(layer7_release_i), .pixel_store_done_o(pixel_store_done_o),
      .read_data_o(read_data_o), .read_valid_o(read_valid_o), .overflow_o(overflow_o));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [127:0] o, input logic [127:0] e);
      n_chk++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask
   function automatic logic [127:0] rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction
   function automatic logic [127:0] pix(input int v);
      return {8{16'(v)}};
   endfunction
   task automatic check_all(input logic erv, input logic [127:0] erd);
      check("done", pixel_store_done_o, rdy);
      check("read_valid", read_valid_o, erv);
      check("read_data", read_data_o, erd);
      check("overflow", overflow_o, ovf);
   endtask
   task automatic cyc(input bit we, input int wr, input int wc, input logic [127:0] wd,
                      input bit rd, input int rr, input int rc, input bit rel);
      bit inr;
      logic erv;
      logic [127:0] erd;
      save_enable_i = we; save_row_i = 16'(wr); save_col_i = 16'(wc); save_data_i = wd;
      read_pixel_signal_i = rd; read_row_addr_i = 16'(rr); read_col_addr_i = 16'(rc);
      layer7_release_i = rel;
      inr = rr >= 0 && rr < 8 && rc >= 0 && rc < 8;
      erv = rd && rdy && (inr || PAD);
      erd = (rd && rdy && inr) ? m[rr * 8 + rc] : '0;
      @(posedge clk);
      if (rdy && rel) begin rdy = 1'b0; cnt = 0; end
      if (we) begin
         if (!rdy && wr >= 0 && wr < 8 && wc >= 0 && wc < 8) begin
            m[wr * 8 + wc] = wd;
            cnt++;
            rdy = cnt == 64;
         end else ovf = 1'b1;
      end
      #1;
      check_all(erv, erd);
      save_enable_i = 1'b0; read_pixel_signal_i = 1'b0; layer7_release_i = 1'b0;
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      cnt = 0; rdy = 1'b0; ovf = 1'b0;
      check_all(1'b0, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask
   initial begin
      do_reset();
      cyc(0, 0, 0, '0, 1, 1, 1, 0);
      for (int i = 0; i < 64; i++) cyc(1, i / 8, i % 8, pix(i), 0, 0, 0, 0);
      check("done_after_64", pixel_store_done_o, 1'b1);
      cyc(0, 0, 0, '0, 1, 3, 5, 0);
      check("rd35", read_data_o, pix(29));
      cyc(0, 0, 0, '0, 1, 0, 0, 0);
      check("rd00", read_data_o, pix(0));
      cyc(0, 0, 0, '0, 1, 7, 7, 0);
      check("rd77", read_data_o, pix(63));
      cyc(0, 0, 0, '0, 1, -1, 4, 0);
      cyc(0, 0, 0, '0, 1, 4, 8, 0);
      cyc(1, 2, 2, rnd(), 0, 0, 0, 0);
      check("ovf_ready_write", overflow_o, 1'b1);
      cyc(0, 0, 0, '0, 1, 2, 2, 0);
      check("rd22_kept", read_data_o, pix(18));
      cyc(1, 0, 0, rnd(), 1, 3, 3, 1);
      check("done_cleared", pixel_store_done_o, 1'b0);
      for (int i = 1; i < 64; i++) cyc(1, i / 8, i % 8, rnd(), 0, 0, 0, 0);
      for (int i = 0; i < 40; i++)
         cyc(0, 0, 0, '0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 11)) - 2,
             int'($urandom_range(0, 11)) - 2, 0);
      cyc(0, 0, 0, '0, 1, 5, 5, 1);
      cyc(0, 0, 0, '0, 1, 5, 5, 1);
      do_reset();
      cyc(1, 8, 0, rnd(), 0, 0, 0, 0);
      check("ovf_oob_fill", overflow_o, 1'b1);
      for (int i = 0; i < 30; i++) cyc(1, i / 8, i % 8, rnd(), 0, 0, 0, 0);
      do_reset();
      for (int t = 0; t < 2000 && !rdy; t++) begin
         if ($urandom_range(0, 7) == 0)
            cyc(1, $urandom_range(0, 1) == 1 ? 8 : -1, cnt % 8, rnd(), 0, 0, 0, 0);
         else
            cyc($urandom_range(0, 3) != 0, cnt / 8, cnt % 8, rnd(), $urandom_range(0, 1) == 1,
                int'($urandom_range(0, 9)) - 1, int'($urandom_range(0, 9)) - 1,
                $urandom_range(0, 3) == 0);
      end
      check("fill_done", pixel_store_done_o, 1'b1);
      for (int i = 0; i < 30; i++)
         cyc(0, 0, 0, '0, 1, int'($urandom_range(0, 9)) - 1, int'($urandom_range(0, 9)) - 1, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
